// File: rtl/niosqsys_pio_pkg.sv
// Shared constants and types for the Avalon-MM input PIO with edge-capture interrupt.
// The optional input debounce is enabled by defining PIO_IN_DEBOUNCE_EN.
package niosqsys_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned MAX_SYNC_STAGES = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Keeps out-of-range stage counts inside the supported 2..MAX_SYNC_STAGES window.
    function automatic int unsigned clamp_sync_stages(input int unsigned n);
        if (n < 2) begin
            return 2;
        end else if (n > MAX_SYNC_STAGES) begin
            return MAX_SYNC_STAGES;
        end
        return n;
    endfunction

endpackage

// File: rtl/niosqsys_pio_sync_edge.sv
// One input bit: synchronizer, optional debounce (PIO_IN_DEBOUNCE_EN), previous-level flop
// and edge selection. Edge output is combinational from registers.
module niosqsys_pio_sync_edge
    import niosqsys_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic level,
    output logic edge_hit
);

    localparam int unsigned STAGES = clamp_sync_stages(SYNC_STAGES);
    localparam edge_type_e EDGE_SEL = edge_type_e'(2'(EDGE_TYPE));

    logic [STAGES-1:0] sync_q;
    logic              synced;
    logic              prev_q;
    logic              rise;
    logic              fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_bit};
        end
    end

    assign synced = sync_q[STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;

    // Any cycle where the raw bit agrees with the held level restarts the stability count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else if (synced == db_level_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q   <= '0;
            db_level_q <= synced;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign level = db_level_q;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign level = synced;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

    always_comb begin
        edge_hit = 1'b0;
        unique case (EDGE_SEL)
            EDGE_RISE: edge_hit = rise;
            EDGE_FALL: edge_hit = fall;
            default:   edge_hit = rise | fall;
        endcase
    end

endmodule

// File: rtl/niosqsys_entrada_pio_irq.sv
// Avalon-MM input PIO: level read-back, RW1C edge capture, interrupt mask and level irq.
// Defining PIO_IN_DEBOUNCE_EN adds a per-bit debounce stage after the synchronizer.
module niosqsys_entrada_pio_irq
    import niosqsys_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned STAGES = clamp_sync_stages(SYNC_STAGES);
`ifdef PIO_IN_DEBOUNCE_EN
    // Debounce delays the first level change, so warm-up must cover it too.
    localparam int unsigned WARM_LAST = STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int unsigned WARM_LAST = STAGES + 1;
`endif
    localparam int unsigned WARM_W = $clog2(WARM_LAST + 1);

    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  edge_raw;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  irq_mask_q;
    logic [WIDTH-1:0]  irq_mask_d;
    logic [WIDTH-1:0]  edge_capture_q;
    logic [WIDTH-1:0]  edge_capture_d;
    logic [WARM_W-1:0] warm_cnt_q;
    logic              warm_done;
    logic              wr_en;
    logic [31:0]       readdata_d;
    logic              unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        niosqsys_pio_sync_edge #(
            .SYNC_STAGES     (STAGES),
            .EDGE_TYPE       (EDGE_TYPE),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync_edge (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .level    (data_in[i]),
            .edge_hit (edge_raw[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            warm_cnt_q <= '0;
        end else if (!warm_done) begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
        end
    end

    assign warm_done = (warm_cnt_q == WARM_W'(WARM_LAST));
    assign edge_det  = warm_done ? edge_raw : '0;
    assign wr_en     = chipselect & ~write_n;

    // A new edge wins over a simultaneous write-1-to-clear on the same bit.
    always_comb begin
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (wr_en && (address == ADDR_MASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
        end
        edge_capture_d = edge_capture_d | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = data_in;
            ADDR_RSVD: readdata_d            = '0;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:   readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata       <= '0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata       <= readdata_d;
        end
    end

    assign irq = |(edge_capture_q & irq_mask_q);

    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_niosqsys_entrada_pio_irq.sv
// Self-checking bench for the input PIO: reads are scored through an expected-value queue.
module tb_niosqsys_entrada_pio_irq;
    import niosqsys_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    niosqsys_entrada_pio_irq #(
        .WIDTH           (4),
        .EDGE_TYPE       (0),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        tick();
        chipselect = 1'b0;
        check_eq(tag, readdata, exp_q.pop_front());
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check_eq(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Inputs held high through reset must never register as edges.
        idle(3);
        check_eq("rst_readdata", readdata, 32'h0);
        check_irq("rst_irq", 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_irq("warm_irq", 1'b0);
        end
        bus_read("warm_capture", ADDR_EDGE, 32'h0);
        bus_read("warm_data", ADDR_DATA, 32'h0000_000F);

        // Falling edges are ignored for rising-edge capture.
        in_port = 4'h0;
        idle(4);
        bus_read("fall_ignored", ADDR_EDGE, 32'h0);

        // Unselected write must not land.
        address   = ADDR_MASK;
        writedata = 32'hF;
        write_n   = 1'b0;
        tick();
        write_n = 1'b1;
        bus_read("nocs_mask", ADDR_MASK, 32'h0);

        // Rising edge on bit 1: capture two edges after sampling.
        bus_write(ADDR_MASK, 32'h2);
        in_port = 4'b0010;
        tick();
        check_irq("lat_irq_k0", 1'b0);
        tick();
        check_irq("lat_irq_k1", 1'b0);
        tick();
        check_irq("lat_irq_k2", 1'b1);
        bus_read("cap_bit1", ADDR_EDGE, 32'h2);

        // Clear coinciding with a new rising edge: set wins.
        in_port = 4'b0000;
        idle(4);
        in_port = 4'b0010;
        tick();
        tick();
        bus_write(ADDR_EDGE, 32'h2);
        check_irq("setwins_irq", 1'b1);
        bus_read("setwins_cap", ADDR_EDGE, 32'h2);
        bus_write(ADDR_EDGE, 32'h2);
        check_irq("clear_irq", 1'b0);
        bus_read("clear_cap", ADDR_EDGE, 32'h0);

        // Masking: bits 0 and 3 captured with mask 0.
        bus_write(ADDR_MASK, 32'h0);
        in_port = 4'b1011;
        idle(4);
        check_irq("mask0_irq", 1'b0);
        bus_read("cap_bits03", ADDR_EDGE, 32'h9);
        bus_write(ADDR_MASK, 32'h8);
        check_irq("mask8_irq", 1'b1);
        bus_write(ADDR_EDGE, 32'h8);
        check_irq("clr3_irq", 1'b0);
        bus_read("clr3_cap", ADDR_EDGE, 32'h1);
        bus_read("mask_rd", ADDR_MASK, 32'h8);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
        bus_read("data_rd", ADDR_DATA, 32'h0000_000B);
        bus_read("rsvd_rd", ADDR_RSVD, 32'h0);

        // Mid-operation reset with everything captured and unmasked.
        in_port = 4'h0;
        idle(4);
        in_port = 4'hF;
        idle(4);
        bus_write(ADDR_MASK, 32'hF);
        check_irq("full_irq", 1'b1);
        bus_read("full_cap", ADDR_EDGE, 32'hF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_irq("rst2_irq", 1'b0);
        check_eq("rst2_readdata", readdata, 32'h0);
        bus_read("rst2_cap", ADDR_EDGE, 32'h0);
        bus_read("rst2_mask", ADDR_MASK, 32'h0);
        idle(10);
        bus_read("rst2_cap_late", ADDR_EDGE, 32'h0);
        bus_read("rst2_data", ADDR_DATA, 32'h0000_000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/niosqsys_entrada_pio_irq.md
Name: niosqsys_entrada_pio_irq

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the LCD mode output PIO.
- Samples an external WIDTH-bit input bus (push-buttons/switches) through a synchronizer and detects edges per bit.
- Latches edges in a write-1-to-clear capture register and raises a level IRQ to the Nios II when a captured bit is unmasked.
- Sits on the Qsys interconnect next to the other PIOs; software reads the level, the captured edges and the mask.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 0, edge that sets capture: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, synchronizer flops per bit (2..4).
- DEBOUNCE_CYCLES, 16, stable-cycle count; used only when PIO_IN_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data; registered, read latency 1.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: reset_n low at a rising clk edge clears the sync chain, prev, irq_mask, edge_capture, readdata and the warm-up counter, all to 0. A mid-operation reset discards pending edges; irq is 0 the cycle after.
- Sync: sync[0] <= in_port; sync[i] <= sync[i-1]. The level is data_in = sync[SYNC_STAGES-1]. prev <= data_in every cycle.
- Edge detect per bit:
  - rise = data_in & ~prev; fall = ~data_in & prev; any = rise | fall.
  - Selected by EDGE_TYPE.
- Warm-up: a counter runs 0..SYNC_STAGES+1 after reset and saturates. Edge detect is forced to 0 until it saturates, so an input held high through reset never produces a capture.
- Latency: in_port stable before clock edge k sets edge_capture at edge k+SYNC_STAGES. irq rises in the same cycle, because irq is combinational from registers.
- Register map (write = chipselect & ~write_n):
  - addr 0: data (RO). Reads {0, data_in}; writes ignored.
  - addr 1: reserved. Reads 0; writes ignored.
  - addr 2: irq_mask (RW). Write loads writedata[WIDTH-1:0].
  - addr 3: edge_capture (RW1C). Write clears each bit whose writedata bit is 1.
- Simultaneous clear and new edge on the same bit: the set wins, and the bit stays 1. Other bits follow their own set/clear independently.
- Capture is sticky: repeated edges on a set bit are absorbed, with no count or overflow.
- Read: readdata <= {32-WIDTH zeros, mux(address)} on every clock, independent of chipselect. Data is valid one cycle after address is presented.
- Unused upper readdata bits are always 0.
- irq = |(edge_capture & irq_mask). Changing the mask takes effect the cycle after the write.

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit gets a counter after the synchronizer.
  - The debounced level updates only after the raw synced bit has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce reloads the counter.
  - data_in and edge detect use the debounced level, which adds DEBOUNCE_CYCLES of latency.
  - The counters clear on reset.
- Undefined: no debounce logic; data_in is the last sync stage.

Decomposition:
- Package niosqsys_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3;
  - the edge_type enum (EDGE_RISE, EDGE_FALL, EDGE_ANY);
  - MAX_SYNC_STAGES=4.
- Sub-module niosqsys_pio_sync_edge is instantiated per bit. It contains the synchronizer, optional debounce, prev flop and edge-select logic, and outputs level and edge.
- The top level keeps the register file, warm-up counter, read mux and irq.

Test Plan:
- Reset release with in_port=4'hF held high, EDGE_TYPE=0 -> edge_capture stays 0 and irq stays 0 for 20 cycles; read addr 0 returns 32'h0000000F.
- Write mask 4'b0010, then pulse in_port[1] 0->1 -> edge_capture=4'b0010 exactly SYNC_STAGES edges after sampling; irq=1; read addr 3 returns 32'h2.
- Write 32'h2 to addr 3 on the same cycle a new rising edge hits bit 1 -> bit 1 remains 1 and irq stays 1. A later clear with no edge gives 0 and irq=0.
- Edges captured on bits 0 and 3 with mask 0 -> irq=0. Write mask 4'b1000 -> irq=1 the next cycle. Clear bit 3 only -> irq=0 and capture=4'b0001.
- Assert reset_n low for 1 cycle with capture=4'hF and mask=4'hF -> all registers 0 and irq=0 the following cycle.
- With PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle glitch produces no change. A 20-cycle-stable high sets capture 16 cycles after the synced edge.
